// File: rtl/wb_write_port_ctrl.sv
// Write-port producer for the register file.
// Merges single-cycle ALU results with handshaked load results. Loads that
// lose arbitration wait in a small FIFO. A lookup port lets decode forward
// values that are still waiting to reach the register file.
module wb_write_port_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [31:0]     alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [31:0]     ld_data,
  output logic            regWrite,
  output logic [4:0]      writeReg,
  output logic [31:0]     writeData,
  input  logic [4:0]      q_reg,
  output logic            q_hit,
  output logic [31:0]     q_data,
  output logic [CNTW-1:0] fifo_count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] sq_q, sq_d;
  logic [4:0]       ent_rd_q [DEPTH];
  logic [4:0]       ent_rd_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [PTRW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [31:0]      write_data_q, write_data_d;
  logic             accept, push, pop;

  // Ready depends only on registered occupancy; forced low while in reset.
  assign ld_ready   = rst_n && (count_q < DEPTH_C);
  assign fifo_count = count_q;
  assign regWrite   = reg_write_q;
  assign writeReg   = write_reg_q;
  assign writeData  = write_data_q;

  // Arbitration, FIFO push/pop and squash of loads made stale by a younger ALU write.
  always_comb begin
    vld_d        = vld_q;
    sq_d         = sq_q;
    ent_rd_d     = ent_rd_q;
    ent_data_d   = ent_data_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    accept       = ld_valid && ld_ready;
    pop          = 1'b0;

    if (alu_valid) begin
      // rd=0 still consumes the slot but never writes.
      if (alu_rd != 5'd0) begin
        reg_write_d  = 1'b1;
        write_reg_d  = alu_rd;
        write_data_d = alu_data;
      end
    end else if (count_q != '0) begin
      pop = 1'b1;
      // A squashed head burns its cycle without writing.
      if (!sq_q[head_q]) begin
        reg_write_d  = 1'b1;
        write_reg_d  = ent_rd_q[head_q];
        write_data_d = ent_data_q[head_q];
      end
    end else if (accept && (ld_rd != 5'd0)) begin
      reg_write_d  = 1'b1;
      write_reg_d  = ld_rd;
      write_data_d = ld_data;
    end

    // Loads to r0 are accepted and dropped; bypassed loads never enter the FIFO.
    push = accept && (ld_rd != 5'd0) && (alu_valid || (count_q != '0));

    if (pop) begin
      vld_d[head_q] = 1'b0;
      sq_d[head_q]  = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_q]      = 1'b1;
      sq_d[tail_q]       = 1'b0;
      ent_rd_d[tail_q]   = ld_rd;
      ent_data_d[tail_q] = ld_data;
      tail_d             = tail_q + 1'b1;
    end

    // The ALU result is younger than every queued load, including one pushed now.
    if (alu_valid && (alu_rd != 5'd0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_d[i] && (ent_rd_d[i] == alu_rd)) sq_d[i] = 1'b1;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Forwarding lookup: youngest live FIFO entry wins, then the value on the port.
  always_comb begin
    q_hit  = 1'b0;
    q_data = 32'd0;
    if (q_reg != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[head_q + PTRW'(i)] && !sq_q[head_q + PTRW'(i)] &&
            (ent_rd_q[head_q + PTRW'(i)] == q_reg)) begin
          q_hit  = 1'b1;
          q_data = ent_data_q[head_q + PTRW'(i)];
        end
      end
      if (!q_hit && reg_write_q && (write_reg_q == q_reg)) begin
        q_hit  = 1'b1;
        q_data = write_data_q;
      end
    end
  end

  // Control and write-port state; reset drops every queued load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      sq_q         <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      vld_q        <= vld_d;
      sq_q         <= sq_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // FIFO payload storage; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk) begin
    ent_rd_q   <= ent_rd_d;
    ent_data_q <= ent_data_d;
  end

endmodule
